// File: rtl/fa_chk_pkg.sv
// Shared types and constants for the full-adder response checker.
package fa_chk_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int VEC_W = 3;
  localparam logic [7:0] COV_FULL = 8'hFF;

endpackage

// File: rtl/fa_response_checker_full_adder.sv
// Reference 1-bit full adder, used as the golden model inside the checker.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/fa_response_checker.sv
// Compares observed full-adder outputs against a golden full_adder over one run of vectors.
// Optional vector-coverage tracking is compiled in with FA_CHK_COVERAGE_EN.
module fa_response_checker
  import fa_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 8,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c_in,
  input  logic             obs_sum,
  input  logic             obs_c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [2:0]       first_fail_vec,
  output logic [7:0]       cov_map
);

  localparam int CNT_W = $clog2(NUM_VECTORS + 1);

  state_t           state;
  logic [CNT_W-1:0] vec_cnt;
  logic [VEC_W-1:0] vec;
  logic             exp_sum;
  logic             exp_c_out;
  logic             accept;
  logic             mismatch;
  logic             last_vec;
  logic             enter_run;
  logic             cov_ok;

  full_adder u_golden (
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (exp_sum),
    .c_out (exp_c_out)
  );

  assign vec       = {a, b, c_in};
  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mismatch  = accept && ((obs_sum != exp_sum) || (obs_c_out != exp_c_out));
  assign last_vec  = (vec_cnt == CNT_W'(NUM_VECTORS - 1));
  assign enter_run = start && ((state == IDLE) || (state == DONE));
  assign pass      = done && (err_count == '0) && cov_ok;

  // Start is honoured only from IDLE or DONE, so a start during a run is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec_cnt          <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (enter_run) begin
      state            <= RUN;
      vec_cnt          <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (state == RUN) begin
      if (accept) begin
        vec_cnt <= vec_cnt + CNT_W'(1);
        if (last_vec) state <= DONE;
        if (mismatch && !(&err_count)) err_count <= err_count + ERR_W'(1);
        if (mismatch && !first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_vec   <= vec;
        end
      end
    end else if (state != DONE) begin
      state <= IDLE;
    end
  end

`ifdef FA_CHK_COVERAGE_EN
  always_ff @(posedge clk) begin
    if (!rst_n || enter_run) cov_map <= '0;
    else if (accept)         cov_map[vec] <= 1'b1;
  end

  assign cov_ok = (cov_map == COV_FULL);
`else
  assign cov_map = '0;
  assign cov_ok  = 1'b1;
`endif

endmodule

// File: doc/fa_response_checker.md
# fa_response_checker

Self-checking response checker for the 1-bit full adder. It sits at the output end of a full-adder test harness. It accepts each applied input vector (a, b, c_in) together with the sum and c_out observed from the unit under test, and compares them against a golden model. Over one run of NUM_VECTORS vectors it counts mismatches and captures the first failing vector. At the end it reports pass/fail to a bench or BIST controller.

## Interface
Parameters:
- NUM_VECTORS, default 8: vectors accepted per run; legal range 1..255.
- ERR_W, default 4: width of the error counter; the counter saturates.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle pulse that begins or restarts a run.
- in_valid  in  1  the vector and observed outputs below are valid this cycle.
- in_ready  out  1  the checker accepts a vector this cycle.
- a, b, c_in  in  1 each  input vector that was applied to the unit under test.
- obs_sum, obs_c_out  in  1 each  outputs observed from the unit under test.
- busy  out  1  a run is in progress.
- done  out  1  the run is complete; level output, held until the next start or reset.
- pass  out  1  valid while done is high: no mismatches (plus full coverage when the coverage feature is compiled in).
- err_count  out  ERR_W  number of mismatches, saturating at 2^ERR_W-1.
- first_fail_valid  out  1  at least one mismatch has been captured.
- first_fail_vec  out  3  {a,b,c_in} of the first mismatching vector.
- cov_map  out  8  bit k set when vector code k={a,b,c_in} has been seen; tied to 0 when the coverage feature is compiled out.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start → RUN.
  - RUN: the final accept → DONE; start is ignored.
  - DONE: start → RUN; a restart is allowed without returning to IDLE.
- Entering RUN clears vec_cnt, err_count, first_fail_*, and cov_map, all in the same edge.
- in_ready = (state==RUN). It is decoded from the registered state only and has no combinational path from inputs.
- An accept is in_valid && in_ready. On each accept:
  - expected sum = a^b^c_in.
  - expected c_out = (a&b)|(a&c_in)|(b&c_in).
  - A mismatch is any difference in sum or c_out.
  - On a mismatch, err_count increments unless it is saturated.
  - On the first mismatch, first_fail_vec <= {a,b,c_in} and first_fail_valid <= 1. Later mismatches do not overwrite the capture.
  - vec_cnt increments. An accept with vec_cnt==NUM_VECTORS-1 is the final accept.
- in_valid outside RUN is ignored; nothing is counted.
- pass = (err_count==0) && done when the coverage feature is compiled out.
- Reset values: state=IDLE; in_ready, busy, done, pass, first_fail_valid = 0; err_count, first_fail_vec, cov_map = 0.
- Reset asserted mid-run aborts the run. Everything returns to reset values on that edge, and results are not retained.

## Timing
- busy rises on the edge that samples start in IDLE or DONE.
- in_ready is high from the cycle after start until the final-accept cycle inclusive.
- err_count, first_fail_*, and cov_map update on the edge that samples the accept, so they are visible the next cycle.
- done and pass rise one cycle after the final accept, in the same cycle that busy falls. Accept-to-result latency is 1 cycle.
- Back-to-back accepts at one vector per cycle are supported. With in_valid held high, a run of 8 completes in 8 cycles after the first in_ready.
- start in the same cycle as the final accept: start is ignored, because the state is RUN.

## Configuration
- Macro FA_CHK_COVERAGE_EN.
  - Defined: cov_map tracks the vector codes seen during the run. pass additionally requires cov_map==8'hFF. A run with no errors but missing codes reports pass=0.
  - Undefined: the coverage logic is removed and cov_map is driven to 0.

## Structure
- Package fa_chk_pkg holds:
  - the state typedef (IDLE/RUN/DONE);
  - localparam VEC_W=3;
  - localparam COV_FULL=8'hFF.
- Sub-module: the existing full_adder instantiated as the golden model inside fa_response_checker. Its outputs are compared against obs_sum/obs_c_out.
- vec_cnt width is $clog2(NUM_VECTORS+1).

## Test plan
- Reset then idle: rst_n low for 2 cycles, then in_valid=1 without start → in_ready, busy, done, err_count all stay 0.
- Clean exhaustive run: start, then codes 0..7 with correct outputs back-to-back → done=1 one cycle after the 8th accept; pass=1, err_count=0, first_fail_valid=0, cov_map=FF (with the macro).
- Injected faults: codes 0..7, with obs_c_out inverted on code 3 and obs_sum inverted on code 6 → err_count=2, first_fail_vec=3'b011, pass=0.
- Saturation: ERR_W=2, NUM_VECTORS=8, every vector wrong → err_count=3, pass=0.
- Coverage hole (macro defined): 8 correct vectors with code 5 repeated and code 7 missing → err_count=0, cov_map=8'h7F, pass=0. With the macro undefined → pass=1.
- Reset mid-run and restart: rst_n low after the 4th accept → all outputs 0 on the next cycle. Then start and a clean run → pass=1. Then start in DONE with a faulty run → the previous results are cleared and the new err_count is reported.
